// File: rtl/pipe_pkg.sv
// Shared widths, control-bit positions and small helpers for the
// writeback pipeline stage register.
package pipe_pkg;

    localparam int DW_DEF = 32;
    localparam int CW_DEF = 2;
    localparam int NW_DEF = 5;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;

    function automatic logic [1:0] occ_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One stage-register slot: a valid bit plus a payload word, loaded on ld.
// clr drops only the valid bit; reset clears everything.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld,
    input  logic          clr,
    input  logic [PW-1:0] d,
    output logic          valid,
    output logic [PW-1:0] q
);

    // Slot register: reset > clear > load > hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= {PW{1'b0}};
        end else if (clr) begin
            valid <= 1'b0;
        end else if (ld) begin
            valid <= 1'b1;
            q     <= d;
        end else begin
            valid <= valid;
            q     <= q;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) valid/ready pipeline register carrying control
// bits, read data, ALU result and destination register number.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF,
    parameter int NW = NW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_ctrl,
    input  logic [DW-1:0] in_rd,
    input  logic [DW-1:0] in_alu,
    input  logic [NW-1:0] in_wn,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_ctrl,
    output logic [DW-1:0] out_rd,
    output logic [DW-1:0] out_alu,
    output logic [NW-1:0] out_wn,
    output logic [1:0]    occ
);

    localparam int PW = CW + DW + DW + NW;

    logic [PW-1:0] in_pl;
    logic [PW-1:0] main_d;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;
    logic          main_v;
    logic          skid_v;
    logic          accept_s;
    logic          release_s;
    logic          main_ld_s;
    logic          main_clr_s;
    logic          skid_ld_s;
    logic          skid_clr_s;

    assign in_pl = {in_ctrl, in_rd, in_alu, in_wn};

    // Handshake decode and per-slot load/clear; flush overrides every move.
    always_comb begin
        accept_s   = in_valid & ~skid_v;
        release_s  = main_v & out_ready;
        main_ld_s  = 1'b0;
        main_clr_s = 1'b0;
        skid_ld_s  = 1'b0;
        skid_clr_s = 1'b0;
        main_d     = in_pl;
        if (flush) begin
            main_clr_s = 1'b1;
            skid_clr_s = 1'b1;
        end else if (release_s && skid_v) begin
            main_ld_s  = 1'b1;
            main_d     = skid_q;
            skid_clr_s = 1'b1;
        end else if (accept_s && (!main_v || release_s)) begin
            main_ld_s  = 1'b1;
        end else if (accept_s) begin
            skid_ld_s  = 1'b1;
        end else if (release_s) begin
            main_clr_s = 1'b1;
        end else begin
            main_ld_s  = 1'b0;
        end
    end

    pipe_entry #(.PW(PW)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (main_ld_s),
        .clr   (main_clr_s),
        .d     (main_d),
        .valid (main_v),
        .q     (main_q)
    );

    pipe_entry #(.PW(PW)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (skid_ld_s),
        .clr   (skid_clr_s),
        .d     (in_pl),
        .valid (skid_v),
        .q     (skid_q)
    );

    // Bubbles present all-zero control so nothing is ever written back.
    assign out_valid = main_v;
    assign out_ctrl  = main_v ? main_q[PW-1 -: CW] : {CW{1'b0}};
    assign out_rd    = main_q[DW+DW+NW-1 -: DW];
    assign out_alu   = main_q[DW+NW-1 -: DW];
    assign out_wn    = main_q[NW-1:0];
    assign in_ready  = ~skid_v;
    assign occ       = occ_count(main_v, skid_v);

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DW, default 32: width of each data word (memory read data, ALU result).
REQ-002 SHALL have parameter CW, default 2: control-bit width (bit0 RegWrite, bit1 MemtoReg by default).
REQ-003 SHALL have parameter NW, default 5: write-register-number width.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1: upstream presents a valid instruction.
REQ-007 SHALL have port in_ready, output, 1: stage accepts the upstream instruction this cycle.
REQ-008 SHALL have port in_ctrl, input, CW: upstream control bits.
REQ-009 SHALL have ports in_rd and in_alu, input, DW each: upstream data words.
REQ-010 SHALL have port in_wn, input, NW: upstream write-register number.
REQ-011 SHALL have port flush, input, 1: discard all held instructions.
REQ-012 SHALL have port out_valid, output, 1: the stage presents a valid instruction.
REQ-013 SHALL have port out_ready, input, 1: downstream consumes the presented instruction.
REQ-014 SHALL have ports out_ctrl (CW), out_rd (DW), out_alu (DW) and out_wn (NW), outputs: presented payload.
REQ-015 SHALL have port occ, output, 2: entries held (0..2).

Function
REQ-016 SHALL hold two entries, main and skid, each holding valid, ctrl, rd, alu and wn.
REQ-017 SHALL drive in_ready = NOT skid.valid, registered with no combinational path from out_ready.
REQ-018 SHALL accept the upstream instruction when in_valid AND in_ready; SHALL release the main entry when out_valid AND out_ready.
REQ-019 SHALL present the main entry on the outputs; out_valid = main.valid.
REQ-020 SHALL force out_ctrl to all-zero whenever out_valid=0, so a bubble never writes the register file.
REQ-021 SHALL have a latency of one cycle: an instruction accepted into an empty stage appears on out_* the next cycle.
REQ-022 SHALL, on accept with the main entry empty or released in the same cycle and the skid entry empty, load the main entry.
REQ-023 SHALL, on accept with the main entry held and not released, load the skid entry.
REQ-024 SHALL, on release with the skid entry valid, move skid into main and clear skid; a same-cycle accept is impossible because in_ready=0.
REQ-025 SHALL keep data in order: out_* SHALL present instructions in acceptance order with no loss or duplication.
REQ-026 SHALL make occ equal main.valid + skid.valid.
REQ-027 SHALL, on flush=1, clear both valid bits at the next edge; flush SHALL take priority over a simultaneous accept and release.
REQ-028 SHALL not clear data fields on flush; only the valid bits are cleared.
REQ-029 SHALL hold all entry contents unchanged while out_ready=0 and no accept occurs (stall).

Reset
REQ-030 SHALL, at a rising clk edge with rst_n=0, clear main.valid and skid.valid; the result is out_valid=0, out_ctrl=0, in_ready=1, occ=0.
REQ-031 SHALL reset out_rd, out_alu and out_wn to zero.
REQ-032 SHALL give reset priority over flush, accept and release.
REQ-033 SHALL, when reset is asserted mid-operation, drop all held instructions with no partial state surviving.

Structure
REQ-034 SHALL place the following in the shared package pipe_pkg: default widths (DW_DEF=32, CW_DEF=2, NW_DEF=5) and control-bit indices (CTRL_REGWRITE=0, CTRL_MEMTOREG=1).
REQ-035 SHALL implement each entry as sub-module pipe_entry, a single load-enabled valid+payload register with synchronous clear; it SHALL be instantiated twice.

Verification
REQ-036 Single pass: accept ctrl=2'b11, alu=0x0000_1234, wn=5'd7 with out_ready=1 -> same values on out_* next cycle, occ=1, then 0.
REQ-037 Stall fill: out_ready=0 while accepting A (alu=0x1) then B (alu=0x2) -> occ=2, in_ready=0, out_alu=0x1 held; then out_ready=1 -> 0x1 then 0x2 on consecutive cycles.
REQ-038 Flush with accept: occ=2 and flush=1 with in_valid=1 in the same cycle -> next cycle occ=0, out_valid=0, out_ctrl=0.
REQ-039 Reset mid-stream: stream of 4 instructions, rst_n=0 for one edge after the second -> outputs zero, in_ready=1, and later instructions flow normally.
REQ-040 Random valid/ready: 1000 random instructions with random in_valid and out_ready -> scoreboard shows exact order, no loss, and out_ctrl=0 whenever out_valid=0.
REQ-041 Width sweep: DW=64, NW=6 -> alu=0xFFFF_FFFF_0000_0001 and wn=6'd63 pass unchanged.
